// File: rtl/uart_32bit_tx.sv
// uart_32bit_tx: serializes a 32-bit word as four back-to-back 8N1 UART
// frames, least-significant byte first. Optional idle gap between bytes.
// The tx line is registered so it never glitches between bit periods.
module uart_32bit_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_start,
  output logic        tx,
  output logic        busy,
  output logic        data_end
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = (GAP_BITS > 0) ? GAP_W'(GAP_BITS - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              data_end_q, data_end_d;

  logic              baud_end;
  logic [7:0]        next_byte;

  assign baud_end  = (baud_cnt_q == BAUD_LAST);
  // The byte that the next START will send: byte_idx_d already points at it.
  assign next_byte = word_q[{byte_idx_d, 3'b000} +: 8];

  // Next-state, counter and output computation for the frame sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;

    case (state_q)
      S_IDLE: begin
        if (data_start) begin
          word_d     = data_in;
          shift_d    = data_in[7:0];
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          baud_cnt_d = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
        if (baud_end) begin
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
        if (baud_end) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (GAP_BITS > 0) begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else begin
              shift_d = next_byte;
              state_d = S_START;
            end
          end
        end
      end

      S_GAP: begin
        baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
        if (baud_end) begin
          if (gap_cnt_q == GAP_LAST) begin
            shift_d = next_byte;
            state_d = S_START;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so the registered copies line
    // up exactly with the state they describe.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d != S_IDLE);
    data_end_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      data_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      data_end_q <= data_end_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign data_end = data_end_q;

endmodule

// File: tb/tb_uart_32bit_tx.sv
// Self-checking bench for uart_32bit_tx. Two instances share clk/reset:
// dut_a has no inter-byte gap, dut_b has a 2-bit gap. A line-level model
// builds the expected tx waveform and a UART receiver model decodes the
// captured line back into a word.
module tb_uart_32bit_tx;

  localparam int CPB = 4;
  localparam int CAP = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_a, din_b;
  logic        start_a, start_b;
  logic        tx_a, busy_a, end_a;
  logic        tx_b, busy_b, end_b;

  int checks = 0;
  int errors = 0;

  logic tx_cap   [0:CAP-1];
  logic busy_cap [0:CAP-1];
  logic end_cap  [0:CAP-1];
  logic exp_wave [0:CAP-1];
  int   exp_len;

  typedef struct {
    logic [31:0] word;
    int          sel;
    int          lat;
  } vec_t;

  vec_t vecs [0:5];

  always #5 clk = ~clk;

  uart_32bit_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(din_a), .data_start(start_a),
    .tx(tx_a), .busy(busy_a), .data_end(end_a)
  );

  uart_32bit_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .data_in(din_b), .data_start(start_b),
    .tx(tx_b), .busy(busy_b), .data_end(end_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_din(input int sel, input logic [31:0] w);
    if (sel == 0) din_a = w; else din_b = w;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  // Present a word; the following posedge is the acceptance edge T.
  task automatic start_word(input int sel, input logic [31:0] w, input bit hold);
    @(negedge clk);
    set_din(sel, w);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(sel, 1'b0);
  endtask

  // Sample n cycles starting at T+1 (offset 0). Optionally change data_in
  // (and pulse data_start) at offset ev_at.
  task automatic capture(input int sel, input int n, input int ev_at,
                         input logic [31:0] ev_word, input bit ev_pulse);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_cap[i]   = (sel == 0) ? tx_a   : tx_b;
      busy_cap[i] = (sel == 0) ? busy_a : busy_b;
      end_cap[i]  = (sel == 0) ? end_a  : end_b;
      if (i == ev_at) begin
        set_din(sel, ev_word);
        if (ev_pulse) set_start(sel, 1'b1);
      end else if (ev_pulse && i == ev_at + 1) begin
        set_start(sel, 1'b0);
      end
    end
  endtask

  // Expected line: four 10-bit frames, each bit CPB cycles, gap idle between.
  task automatic build_model(input logic [31:0] w, input int gap);
    int   n;
    logic [7:0] b;
    logic v;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      b = 8'((w >> (8 * k)) & 32'hFF);
      for (int bi = 0; bi < 10; bi++) begin
        if (bi == 0)      v = 1'b0;
        else if (bi == 9) v = 1'b1;
        else              v = b[bi-1];
        for (int c = 0; c < CPB; c++) begin
          exp_wave[n] = v;
          n++;
        end
      end
      if (k < 3) begin
        for (int c = 0; c < gap * CPB; c++) begin
          exp_wave[n] = 1'b1;
          n++;
        end
      end
    end
    exp_len = n;
  endtask

  // Receiver model: find each falling edge, sample bits at mid-period.
  task automatic decode(input int base, input int limit, output logic [31:0] w, output logic ok);
    int idx;
    int s;
    w   = '0;
    ok  = 1'b1;
    idx = base;
    for (int k = 0; k < 4; k++) begin
      while (idx < limit && tx_cap[idx] !== 1'b0) idx++;
      if (idx >= limit || idx + CPB / 2 + 9 * CPB >= CAP) begin
        ok = 1'b0;
        return;
      end
      s = idx;
      for (int b = 0; b < 8; b++) w[8*k+b] = tx_cap[s + CPB/2 + (b+1)*CPB];
      if (tx_cap[s + CPB/2 + 9*CPB] !== 1'b1) ok = 1'b0;
      idx = s + CPB/2 + 9*CPB + 1;
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input int gap,
                            input int lat, input int base);
    int   mism, fe, cnt, bc;
    logic [31:0] got;
    logic ok;
    build_model(w, gap);
    mism = 0;
    for (int i = 0; i < exp_len; i++) if (tx_cap[base+i] !== exp_wave[i]) mism++;
    check({tag, ".tx_wave_mismatches"}, mism, 0);
    fe = -1; cnt = 0; bc = 0;
    for (int i = 0; i <= lat + 1; i++) begin
      if (end_cap[base+i] === 1'b1) begin
        cnt++;
        if (fe < 0) fe = i;
      end
    end
    for (int i = 0; i <= lat; i++) if (busy_cap[base+i] === 1'b1) bc++;
    check({tag, ".data_end_offset"}, fe, lat);
    check({tag, ".data_end_count"}, cnt, 1);
    check({tag, ".busy_cycles"}, bc, lat + 1);
    check({tag, ".busy_after_end"}, busy_cap[base+lat+1], 0);
    check({tag, ".tx_at_end"}, tx_cap[base+lat], 1);
    decode(base, base + lat + 1, got, ok);
    check({tag, ".rx_frame_ok"}, ok, 1);
    check({tag, ".rx_word"}, got, w);
  endtask

  initial begin
    int ones, cnt_end, cnt_busy, mism;
    logic [31:0] w1, w2;

    reset = 1'b1;
    din_a = '0; din_b = '0;
    start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", {tx_a, busy_a, end_a}, 3'b100);
    check("reset_b", {tx_b, busy_b, end_b}, 3'b100);
    reset = 1'b0;

    // Latency per word: 40*CPB (+ 3*2*CPB with the gap instance).
    vecs[0] = '{32'hA5C3_0F81, 0, 160};
    vecs[1] = '{32'hDEAD_BEEF, 0, 160};
    vecs[2] = '{32'h0000_00FF, 1, 184};
    vecs[3] = '{$urandom, 0, 160};
    vecs[4] = '{$urandom, 1, 184};
    vecs[5] = '{$urandom, 0, 160};

    for (int v = 0; v < 6; v++) begin
      start_word(vecs[v].sel, vecs[v].word, 1'b0);
      capture(vecs[v].sel, vecs[v].lat + 3, -1, '0, 1'b0);
      check_word($sformatf("vec%0d", v), vecs[v].word, vecs[v].sel * 2, vecs[v].lat, 0);
      if (vecs[v].sel == 1) begin
        ones = 0;
        for (int i = 40; i < 48; i++) if (tx_cap[i] === 1'b1) ones++;
        check($sformatf("vec%0d.gap_idle_cycles", v), ones, 8);
        check($sformatf("vec%0d.start_after_gap", v), tx_cap[48], 0);
      end
    end

    // Start re-pulsed mid-word with a different data_in: must be ignored.
    start_word(0, 32'hCAFE_F00D, 1'b0);
    capture(0, 163, 50, 32'h1234_5678, 1'b1);
    check_word("repulse", 32'hCAFE_F00D, 0, 160, 0);

    // data_start held high: second word accepted right after data_end.
    w1 = $urandom;
    w2 = $urandom;
    start_word(0, w1, 1'b1);
    capture(0, 324, 0, w2, 1'b0);
    start_a = 1'b0;
    check_word("b2b_first", w1, 0, 160, 0);
    check("b2b.tx_idle_gap", tx_cap[161], 1);
    check("b2b.second_start", tx_cap[162], 0);
    check_word("b2b_second", w2, 0, 160, 162);

    // Reset during the 2nd data bit of byte 2 (offsets 88..91).
    w1 = 32'h5A5A_3C3C;
    start_word(0, w1, 1'b0);
    capture(0, 90, -1, '0, 1'b0);
    build_model(w1, 0);
    mism = 0;
    for (int i = 0; i < 90; i++) if (tx_cap[i] !== exp_wave[i]) mism++;
    check("midreset.partial_wave", mism, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset.outputs", {tx_a, busy_a, end_a}, 3'b100);
    reset = 1'b0;
    capture(0, 200, -1, '0, 1'b0);
    cnt_end = 0; cnt_busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (end_cap[i] !== 1'b0) cnt_end++;
      if (busy_cap[i] !== 1'b0 || tx_cap[i] !== 1'b1) cnt_busy++;
    end
    check("midreset.no_data_end", cnt_end, 0);
    check("midreset.stays_idle", cnt_busy, 0);
    w1 = $urandom;
    start_word(0, w1, 1'b0);
    capture(0, 163, -1, '0, 1'b0);
    check_word("after_reset", w1, 0, 160, 0);

    // Reset and data_start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    din_a = 32'hFFFF_FFFF;
    start_a = 1'b1;
    @(negedge clk);
    check("reset_vs_start", {tx_a, busy_a, end_a}, 3'b100);
    reset = 1'b0;
    start_a = 1'b0;
    capture(0, 10, -1, '0, 1'b0);
    cnt_busy = 0;
    for (int i = 0; i < 10; i++) if (busy_cap[i] !== 1'b0) cnt_busy++;
    check("reset_vs_start.idle", cnt_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
